energy_accumulator: RTL and testbench

Sequential accumulator that sits directly downstream of the per-spin partial energy calculator in the energy monitor. It collects one signed local energy per spin over a valid/ready handshake, sums them into a total Hamiltonian value for the current spin configuration, and publishes the total through an output valid/ready handshake. It also drives the index of the next expected spin to the upstream stage. It tracks the minimum total energy seen since reset and flags each result that sets a new minimum.

---
 rtl/energy_accumulator_if.sv | 42 ++++
 rtl/energy_accumulator.sv | 125 ++++++++++++
 tb/tb_energy_accumulator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/energy_accumulator_if.sv
// Handshake bundle between the energy accumulator and its neighbours.
//   slave  : accumulator side (takes start/energy, returns totals and status)
//   master : environment side (upstream partial-energy stage plus total consumer)
// Signals:
//   start_i, num_spin_i                  frame launch and requested length
//   energy_valid_i/energy_ready_o/energy_i, spin_idx_o   partial-energy stream
//   total_valid_o/total_ready_i/total_energy_o, is_best_o frame total stream
//   best_energy_o, best_valid_o, busy_o  running minimum and status
interface energy_accumulator_if #(
  parameter int unsigned LOCAL_ENERGY_BIT = 16,
  parameter int unsigned DATASPIN         = 256,
  parameter int unsigned CNT_BIT          = $clog2(DATASPIN) + 1,
  parameter int unsigned TOTAL_ENERGY_BIT = LOCAL_ENERGY_BIT + $clog2(DATASPIN)
) ();

  logic                               start_i;
  logic        [CNT_BIT-1:0]          num_spin_i;
  logic                               energy_valid_i;
  logic                               energy_ready_o;
  logic signed [LOCAL_ENERGY_BIT-1:0] energy_i;
  logic        [CNT_BIT-1:0]          spin_idx_o;
  logic                               total_valid_o;
  logic                               total_ready_i;
  logic signed [TOTAL_ENERGY_BIT-1:0] total_energy_o;
  logic                               is_best_o;
  logic signed [TOTAL_ENERGY_BIT-1:0] best_energy_o;
  logic                               best_valid_o;
  logic                               busy_o;

  modport slave (
    input  start_i, num_spin_i, energy_valid_i, energy_i, total_ready_i,
    output energy_ready_o, spin_idx_o, total_valid_o, total_energy_o, is_best_o,
           best_energy_o, best_valid_o, busy_o
  );

  modport master (
    output start_i, num_spin_i, energy_valid_i, energy_i, total_ready_i,
    input  energy_ready_o, spin_idx_o, total_valid_o, total_energy_o, is_best_o,
           best_energy_o, best_valid_o, busy_o
  );

endinterface

// File: rtl/energy_accumulator.sv
// Sums one signed partial energy per spin into a frame total (Hamiltonian),
// publishes it over a valid/ready handshake and tracks the minimum total seen
// since reset.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous reset, active-high
//   bus    : energy_accumulator_if.slave (start, energy stream, total stream,
//            best record, busy)
module energy_accumulator #(
  parameter int unsigned LOCAL_ENERGY_BIT = 16,
  parameter int unsigned DATASPIN         = 256,
  parameter int unsigned CNT_BIT          = $clog2(DATASPIN) + 1,
  parameter int unsigned TOTAL_ENERGY_BIT = LOCAL_ENERGY_BIT + $clog2(DATASPIN)
) (
  input logic                 clk_i,
  input logic                 rst_i,
  energy_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [CNT_BIT-1:0] MaxSpin = CNT_BIT'(DATASPIN);

  state_e                             state_q, state_d;
  logic        [CNT_BIT-1:0]          n_q, n_d;
  logic        [CNT_BIT-1:0]          cnt_q, cnt_d;
  logic signed [TOTAL_ENERGY_BIT-1:0] acc_q, acc_d;
  logic signed [TOTAL_ENERGY_BIT-1:0] best_q, best_d;
  logic                               best_valid_q, best_valid_d;
  logic                               is_best_q, is_best_d;

  logic        [CNT_BIT-1:0]          n_start;
  logic signed [TOTAL_ENERGY_BIT-1:0] energy_ext;
  logic                               enter_done;
  logic                               new_best;

  // Requests longer than the spin array are clamped to its size.
  assign n_start    = (bus.num_spin_i > MaxSpin) ? MaxSpin : bus.num_spin_i;
  assign energy_ext = {{(TOTAL_ENERGY_BIT - LOCAL_ENERGY_BIT){bus.energy_i[LOCAL_ENERGY_BIT-1]}},
                       bus.energy_i};

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;
    is_best_d    = is_best_q;
    enter_done   = 1'b0;
    new_best     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          n_d   = n_start;
          cnt_d = '0;
          acc_d = '0;
          if (n_start == '0) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (bus.energy_valid_i) begin
          acc_d = acc_q + energy_ext;
          cnt_d = cnt_q + CNT_BIT'(1);
          if (cnt_q == n_q - CNT_BIT'(1)) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.total_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Compare the total that is about to be published; ties do not count.
    if (enter_done) begin
      new_best  = !best_valid_q || (acc_d < best_q);
      is_best_d = new_best;
      if (new_best) begin
        best_d       = acc_d;
        best_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      n_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      best_valid_q <= 1'b0;
      is_best_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
      is_best_q    <= is_best_d;
    end
  end

  assign bus.energy_ready_o = (state_q == StAccum);
  assign bus.total_valid_o  = (state_q == StDone);
  assign bus.busy_o         = (state_q != StIdle);
  assign bus.spin_idx_o     = cnt_q;
  assign bus.total_energy_o = acc_q;
  assign bus.is_best_o      = is_best_q;
  assign bus.best_energy_o  = best_q;
  assign bus.best_valid_o   = best_valid_q;

endmodule

// File: tb/tb_energy_accumulator.sv
module tb_energy_accumulator;

  localparam int LOCAL_ENERGY_BIT = 16;
  localparam int DATASPIN         = 256;
  localparam int CNT_BIT          = $clog2(DATASPIN) + 1;
  localparam int TOTAL_ENERGY_BIT = LOCAL_ENERGY_BIT + $clog2(DATASPIN);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  energy_accumulator_if #(
    .LOCAL_ENERGY_BIT(LOCAL_ENERGY_BIT),
    .DATASPIN        (DATASPIN),
    .CNT_BIT         (CNT_BIT),
    .TOTAL_ENERGY_BIT(TOTAL_ENERGY_BIT)
  ) bus ();

  energy_accumulator #(
    .LOCAL_ENERGY_BIT(LOCAL_ENERGY_BIT),
    .DATASPIN        (DATASPIN),
    .CNT_BIT         (CNT_BIT),
    .TOTAL_ENERGY_BIT(TOTAL_ENERGY_BIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Scoreboard: expected frame results, pushed at frame launch.
  longint sb_total[$];
  bit     sb_best[$];

  // Reference model of the best record.
  longint m_best       = 0;
  bit     m_best_valid = 1'b0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ":busy"},        longint'(bus.busy_o), 0);
    check_eq({tag, ":energy_rdy"},  longint'(bus.energy_ready_o), 0);
    check_eq({tag, ":total_vld"},   longint'(bus.total_valid_o), 0);
    check_eq({tag, ":total"},       longint'(bus.total_energy_o), 0);
    check_eq({tag, ":spin_idx"},    longint'(bus.spin_idx_o), 0);
    check_eq({tag, ":is_best"},     longint'(bus.is_best_o), 0);
    check_eq({tag, ":best"},        longint'(bus.best_energy_o), 0);
    check_eq({tag, ":best_vld"},    longint'(bus.best_valid_o), 0);
  endtask

  task automatic run_frame(input string tag, input int n_req, input int vals[$],
                           input bit gaps, input int bp);
    int     n;
    longint exp_tot;
    bit     exp_best;
    longint q_tot;
    bit     q_best;

    n = (n_req > DATASPIN) ? DATASPIN : n_req;
    exp_tot = 0;
    for (int i = 0; i < n; i++) exp_tot += vals[i];
    exp_best = !m_best_valid || (exp_tot < m_best);
    if (exp_best) begin
      m_best       = exp_tot;
      m_best_valid = 1'b1;
    end
    sb_total.push_back(exp_tot);
    sb_best.push_back(exp_best);

    bus.start_i    = 1'b1;
    bus.num_spin_i = CNT_BIT'(n_req);
    tick();
    bus.start_i = 1'b0;

    if (n == 0) begin
      check_eq({tag, ":no_energy_rdy"}, longint'(bus.energy_ready_o), 0);
    end else begin
      check_eq({tag, ":busy_t1"}, longint'(bus.busy_o), 1);
      check_eq({tag, ":rdy_t1"},  longint'(bus.energy_ready_o), 1);
      for (int i = 0; i < n; i++) begin
        if (gaps) begin
          int g;
          g = int'($urandom_range(0, 2));
          for (int k = 0; k < g; k++) begin
            bus.energy_valid_i = 1'b0;
            bus.energy_i       = LOCAL_ENERGY_BIT'($urandom);
            tick();
            check_eq({tag, ":stall_idx"}, longint'(bus.spin_idx_o), i);
            check_eq({tag, ":stall_tv"},  longint'(bus.total_valid_o), 0);
          end
        end
        check_eq({tag, ":spin_idx"}, longint'(bus.spin_idx_o), i);
        bus.energy_valid_i = 1'b1;
        bus.energy_i       = LOCAL_ENERGY_BIT'(vals[i]);
        tick();
      end
      bus.energy_valid_i = 1'b0;
    end

    // One cycle after the last accept (or after start for an empty frame).
    check_eq({tag, ":total_vld"}, longint'(bus.total_valid_o), 1);
    if (bus.total_valid_o && sb_total.size() > 0) begin
      q_tot  = sb_total.pop_front();
      q_best = sb_best.pop_front();
    end else begin
      q_tot  = exp_tot;
      q_best = exp_best;
      void'(sb_total.pop_front());
      void'(sb_best.pop_front());
    end
    check_eq({tag, ":total"},    longint'(bus.total_energy_o), q_tot);
    check_eq({tag, ":is_best"},  longint'(bus.is_best_o), longint'(q_best));
    check_eq({tag, ":best"},     longint'(bus.best_energy_o), m_best);
    check_eq({tag, ":best_vld"}, longint'(bus.best_valid_o), 1);
    check_eq({tag, ":idx_n"},    longint'(bus.spin_idx_o), n);
    check_eq({tag, ":rdy_done"}, longint'(bus.energy_ready_o), 0);

    for (int k = 0; k < bp; k++) begin
      bus.total_ready_i = 1'b0;
      bus.start_i       = 1'b1;
      tick();
      check_eq({tag, ":bp_vld"},   longint'(bus.total_valid_o), 1);
      check_eq({tag, ":bp_total"}, longint'(bus.total_energy_o), q_tot);
      check_eq({tag, ":bp_best"},  longint'(bus.is_best_o), longint'(q_best));
    end

    // Handshake cycle with start_i asserted: start must be ignored.
    bus.total_ready_i = 1'b1;
    bus.start_i       = 1'b1;
    bus.num_spin_i    = CNT_BIT'(3);
    tick();
    bus.total_ready_i = 1'b0;
    bus.start_i       = 1'b0;
    check_eq({tag, ":idle_busy"}, longint'(bus.busy_o), 0);
    check_eq({tag, ":idle_tv"},   longint'(bus.total_valid_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int vals[$];

    // Reset with random inputs.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.start_i        = 1'($urandom);
      bus.num_spin_i     = CNT_BIT'($urandom);
      bus.energy_valid_i = 1'($urandom);
      bus.energy_i       = LOCAL_ENERGY_BIT'($urandom);
      bus.total_ready_i  = 1'($urandom);
      tick();
    end
    check_all_zero("reset");
    bus.start_i        = 1'b0;
    bus.num_spin_i     = '0;
    bus.energy_valid_i = 1'b0;
    bus.energy_i       = '0;
    bus.total_ready_i  = 1'b0;
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Basic frame and best tracking: totals 8, 8, -2.
    vals = '{5, -3, 7, -1};
    run_frame("basic", 4, vals, 1'b0, 0);
    vals = '{4, 4};
    run_frame("equal", 2, vals, 1'b0, 1);
    vals = '{-1, 0, -1};
    run_frame("lower", 3, vals, 1'b0, 0);
    check_eq("best_end", longint'(bus.best_energy_o), -2);

    // Stalls and back-pressure on the most negative inputs.
    vals = '{-32768, -32768, -32768};
    run_frame("stall", 3, vals, 1'b1, 5);

    // Empty frame.
    vals = {};
    run_frame("empty", 0, vals, 1'b0, 0);

    // Over-length request clamps to DATASPIN.
    vals = {};
    for (int i = 0; i < DATASPIN + 5; i++) vals.push_back(1);
    run_frame("clamp", DATASPIN + 5, vals, 1'b0, 0);

    // Reset mid-frame after 2 of 4 inputs.
    bus.start_i    = 1'b1;
    bus.num_spin_i = CNT_BIT'(4);
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.energy_valid_i = 1'b1;
      bus.energy_i       = LOCAL_ENERGY_BIT'(3);
      tick();
    end
    bus.energy_valid_i = 1'b0;
    check_eq("midrst_pre_idx", longint'(bus.spin_idx_o), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    m_best       = 0;
    m_best_valid = 1'b0;
    tick();
    vals = '{9};
    run_frame("after_rst", 1, vals, 1'b0, 0);

    check_eq("sb_empty", longint'(sb_total.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
